// File: rtl/ts_rx_analyzer.sv
// Per-lane receive training-set analyzer: decodes TS1/TS2, counts consecutive
// identical sets and flags malformed sets and receive silence for core_fsm.
module ts_rx_analyzer #(
  parameter int CONS_THRESH = 8,
  parameter int RX_TMO      = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [127:0] ts_i,
  input  logic         ts_i_vld,
  output logic [1:0]   ts_type,
  output logic [7:0]   link_num,
  output logic [7:0]   lane_num,
  output logic         link_pad,
  output logic         lane_pad,
  output logic [7:0]   rate_id,
  output logic [7:0]   train_ctrl,
  output logic [7:0]   cons_cnt,
  output logic         ts1_enough,
  output logic         ts2_enough,
  output logic         bad_ts,
  output logic         rx_tmo
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  localparam logic [1:0] TYPE_NONE = 2'd0;
  localparam logic [1:0] TYPE_TS1  = 2'd1;
  localparam logic [1:0] TYPE_TS2  = 2'd2;

  localparam logic [7:0]  THRESH   = CONS_THRESH[7:0];
  localparam logic [15:0] TMO_CNT  = RX_TMO[15:0];
  localparam logic [7:0]  SYM_COM  = 8'hBC;
  localparam logic [7:0]  SYM_TS1  = 8'h4A;
  localparam logic [7:0]  SYM_TS2  = 8'h45;
  localparam logic [7:0]  SYM_PAD  = 8'hF7;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [41:0] key_q;
  logic [41:0] key_nxt;
  logic [1:0]  type_nxt;
  logic [7:0]  cons_nxt;
  logic        load_fields;
  logic [15:0] idle_cnt;

  logic        com_ok;
  logic        is_ts1;
  logic        is_ts2;
  logic [1:0]  rx_type;
  logic [41:0] rx_key;
  logic        good_ts;
  logic        malformed_ts;

  // Combinational decode of the incoming set; the identifier covers symbols 6..15.
  always_comb begin
    is_ts1 = 1'b1;
    is_ts2 = 1'b1;
    for (int k = 6; k < 16; k++) begin
      if (ts_i[8*k +: 8] != SYM_TS1) is_ts1 = 1'b0;
      if (ts_i[8*k +: 8] != SYM_TS2) is_ts2 = 1'b0;
    end
  end

  assign com_ok  = (ts_i[7:0] == SYM_COM);
  assign rx_type = is_ts1 ? TYPE_TS1 : (is_ts2 ? TYPE_TS2 : TYPE_NONE);
  assign rx_key  = {rx_type, ts_i[47:8]};

  // clr discards any set arriving in the same cycle.
  assign good_ts      = ts_i_vld && !clr && com_ok && (is_ts1 || is_ts2);
  assign malformed_ts = ts_i_vld && !clr && !(com_ok && (is_ts1 || is_ts2));

  always_comb begin
    state_nxt   = state;
    type_nxt    = ts_type;
    cons_nxt    = cons_cnt;
    key_nxt     = key_q;
    load_fields = 1'b0;
    if (clr || malformed_ts) begin
      state_nxt = ST_IDLE;
      type_nxt  = TYPE_NONE;
      cons_nxt  = 8'd0;
    end else if (good_ts) begin
      if ((state == ST_TRACK || state == ST_LOCK) && rx_key == key_q) begin
        cons_nxt = (cons_cnt == 8'hFF) ? 8'hFF : cons_cnt + 8'd1;
      end else begin
        load_fields = 1'b1;
        key_nxt     = rx_key;
        type_nxt    = rx_type;
        cons_nxt    = 8'd1;
      end
      state_nxt = (cons_nxt >= THRESH) ? ST_LOCK : ST_TRACK;
    end
  end

  // Tracking state, decoded fields and threshold flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      key_q      <= '0;
      ts_type    <= TYPE_NONE;
      cons_cnt   <= 8'd0;
      link_num   <= 8'd0;
      lane_num   <= 8'd0;
      rate_id    <= 8'd0;
      train_ctrl <= 8'd0;
      ts1_enough <= 1'b0;
      ts2_enough <= 1'b0;
      bad_ts     <= 1'b0;
    end else begin
      state      <= state_nxt;
      key_q      <= key_nxt;
      ts_type    <= type_nxt;
      cons_cnt   <= cons_nxt;
      ts1_enough <= (cons_nxt >= THRESH) && (type_nxt == TYPE_TS1);
      ts2_enough <= (cons_nxt >= THRESH) && (type_nxt == TYPE_TS2);
      bad_ts     <= malformed_ts;
      if (load_fields) begin
        link_num   <= ts_i[15:8];
        lane_num   <= ts_i[23:16];
        rate_id    <= ts_i[39:32];
        train_ctrl <= ts_i[47:40];
      end
    end
  end

  // Receive-silence counter; any valid cycle or a flush restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= 16'd0;
    end else if (clr || ts_i_vld) begin
      idle_cnt <= 16'd0;
    end else if (idle_cnt != 16'hFFFF) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign rx_tmo   = (idle_cnt >= TMO_CNT);
  assign link_pad = (link_num == SYM_PAD);
  assign lane_pad = (lane_num == SYM_PAD);

endmodule

// File: tb/tb_ts_rx_analyzer.sv
// Directed self-checking bench for ts_rx_analyzer with CONS_THRESH=8, RX_TMO=1024.
`timescale 1ns/100ps
module tb_ts_rx_analyzer;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic [127:0] ts_i;
  logic         ts_i_vld;
  logic [1:0]   ts_type;
  logic [7:0]   link_num;
  logic [7:0]   lane_num;
  logic         link_pad;
  logic         lane_pad;
  logic [7:0]   rate_id;
  logic [7:0]   train_ctrl;
  logic [7:0]   cons_cnt;
  logic         ts1_enough;
  logic         ts2_enough;
  logic         bad_ts;
  logic         rx_tmo;

  int checks = 0;
  int errors = 0;

  ts_rx_analyzer #(.CONS_THRESH(8), .RX_TMO(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .ts_i       (ts_i),
    .ts_i_vld   (ts_i_vld),
    .ts_type    (ts_type),
    .link_num   (link_num),
    .lane_num   (lane_num),
    .link_pad   (link_pad),
    .lane_pad   (lane_pad),
    .rate_id    (rate_id),
    .train_ctrl (train_ctrl),
    .cons_cnt   (cons_cnt),
    .ts1_enough (ts1_enough),
    .ts2_enough (ts2_enough),
    .bad_ts     (bad_ts),
    .rx_tmo     (rx_tmo)
  );

  always #0.5 clk = ~clk;

  function automatic logic [127:0] mk_ts(input logic [7:0] com, input logic [7:0] link,
                                         input logic [7:0] lane, input logic [7:0] rate,
                                         input logic [7:0] ctrl, input logic [7:0] id);
    logic [127:0] t;
    t = '0;
    t[7:0]   = com;
    t[15:8]  = link;
    t[23:16] = lane;
    t[31:24] = 8'h10;
    t[39:32] = rate;
    t[47:40] = ctrl;
    for (int k = 6; k < 16; k++) t[8*k +: 8] = id;
    return t;
  endfunction

  // Drive one cycle at the falling edge, then sample just after the rising edge.
  task automatic apply_stimulus(input logic [127:0] ts, input logic vld, input logic clr_in);
    @(negedge clk);
    ts_i     = ts;
    ts_i_vld = vld;
    clr      = clr_in;
    @(posedge clk);
    #0.1;
    ts_i_vld = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #0.1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  logic [127:0] ts1_pad;
  logic [127:0] ts1_a;
  logic [127:0] ts1_b;
  logic [127:0] ts2_b;
  logic [127:0] ts2_x;
  logic [127:0] bad_com;
  logic [127:0] bad_id;

  initial begin
    ts1_pad = mk_ts(8'hBC, 8'hF7, 8'hF7, 8'h02, 8'h00, 8'h4A);
    ts1_a   = mk_ts(8'hBC, 8'h01, 8'h00, 8'h02, 8'h00, 8'h4A);
    ts1_b   = mk_ts(8'hBC, 8'h01, 8'h01, 8'h02, 8'h00, 8'h4A);
    ts2_b   = mk_ts(8'hBC, 8'h01, 8'h01, 8'h02, 8'h00, 8'h45);
    ts2_x   = mk_ts(8'hBC, 8'h01, 8'h05, 8'h06, 8'h00, 8'h45);
    bad_com = mk_ts(8'h00, 8'h01, 8'h01, 8'h02, 8'h00, 8'h4A);
    bad_id  = mk_ts(8'hBC, 8'h01, 8'h01, 8'h02, 8'h00, 8'h00);

    rst = 1'b0; clr = 1'b0; ts_i = '0; ts_i_vld = 1'b0;
    #2.2;
    check_output("reset ts_type", 16'(ts_type), 16'd0);
    check_output("reset cons_cnt", 16'(cons_cnt), 16'd0);
    check_output("reset link_num", 16'(link_num), 16'd0);
    check_output("reset flags", {10'd0, link_pad, lane_pad, ts1_enough, ts2_enough, bad_ts, rx_tmo}, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] eight identical padded TS1s");
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(ts1_pad, 1'b1, 1'b0);
      check_output("ts1 run cons_cnt", 16'(cons_cnt), 16'(i));
      check_output("ts1 run ts1_enough", 16'(ts1_enough), 16'(i >= 8));
    end
    check_output("ts1 run ts_type", 16'(ts_type), 16'd1);
    check_output("ts1 run pads", {14'd0, link_pad, lane_pad}, 16'b11);
    check_output("ts1 run ts2_enough", 16'(ts2_enough), 16'd0);
    check_output("ts1 run rate_id", 16'(rate_id), 16'h02);

    $display("[TB] key change on lane number");
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(ts1_a, 1'b1, 1'b0);
      check_output("lane0 cons_cnt", 16'(cons_cnt), 16'(i));
    end
    check_output("lane0 ts1_enough", 16'(ts1_enough), 16'd0);
    check_output("lane0 link_pad", 16'(link_pad), 16'd0);
    apply_stimulus(ts1_b, 1'b1, 1'b0);
    check_output("lane1 cons_cnt", 16'(cons_cnt), 16'd1);
    check_output("lane1 lane_num", 16'(lane_num), 16'h01);
    for (int i = 2; i <= 8; i++) begin
      apply_stimulus(ts1_b, 1'b1, 1'b0);
      check_output("lane1 ts1_enough", 16'(ts1_enough), 16'(i >= 8));
    end
    check_output("lane1 final cons_cnt", 16'(cons_cnt), 16'd8);

    $display("[TB] 300 TS2s saturate the counter");
    for (int i = 1; i <= 300; i++) begin
      apply_stimulus(ts2_b, 1'b1, 1'b0);
      check_output("ts2 cons_cnt", 16'(cons_cnt), (i > 255) ? 16'd255 : 16'(i));
      check_output("ts2 ts2_enough", 16'(ts2_enough), 16'(i >= 8));
    end
    check_output("ts2 ts1_enough", 16'(ts1_enough), 16'd0);
    check_output("ts2 ts_type", 16'(ts_type), 16'd2);
    apply_stimulus(ts1_b, 1'b1, 1'b0);
    check_output("ts2->ts1 cons_cnt", 16'(cons_cnt), 16'd1);
    check_output("ts2->ts1 ts_type", 16'(ts_type), 16'd1);
    check_output("ts2->ts1 ts2_enough", 16'(ts2_enough), 16'd0);

    $display("[TB] malformed sets");
    for (int i = 2; i <= 8; i++) apply_stimulus(ts1_b, 1'b1, 1'b0);
    check_output("pre-bad ts1_enough", 16'(ts1_enough), 16'd1);
    apply_stimulus(bad_com, 1'b1, 1'b0);
    check_output("bad com bad_ts", 16'(bad_ts), 16'd1);
    check_output("bad com cons_cnt", 16'(cons_cnt), 16'd0);
    check_output("bad com ts_type", 16'(ts_type), 16'd0);
    check_output("bad com enough", {14'd0, ts1_enough, ts2_enough}, 16'd0);
    check_output("bad com lane_num hold", 16'(lane_num), 16'h01);
    idle_cycles(1);
    check_output("bad pulse width", 16'(bad_ts), 16'd0);
    apply_stimulus(ts1_b, 1'b1, 1'b0);
    check_output("after bad cons_cnt", 16'(cons_cnt), 16'd1);
    check_output("after bad ts_type", 16'(ts_type), 16'd1);
    apply_stimulus(bad_id, 1'b1, 1'b0);
    check_output("bad id bad_ts", 16'(bad_ts), 16'd1);
    check_output("bad id cons_cnt", 16'(cons_cnt), 16'd0);
    apply_stimulus(ts1_b, 1'b1, 1'b0);
    check_output("after bad id cons_cnt", 16'(cons_cnt), 16'd1);

    $display("[TB] receive timeout");
    idle_cycles(1023);
    check_output("tmo at 1023", 16'(rx_tmo), 16'd0);
    idle_cycles(1);
    check_output("tmo at 1024", 16'(rx_tmo), 16'd1);
    check_output("tmo keeps cons_cnt", 16'(cons_cnt), 16'd1);
    apply_stimulus(ts1_b, 1'b1, 1'b0);
    check_output("tmo cleared", 16'(rx_tmo), 16'd0);
    check_output("tmo state kept", 16'(cons_cnt), 16'd2);

    $display("[TB] clr with simultaneous valid");
    for (int i = 3; i <= 8; i++) apply_stimulus(ts1_b, 1'b1, 1'b0);
    check_output("pre-clr ts1_enough", 16'(ts1_enough), 16'd1);
    apply_stimulus(ts2_x, 1'b1, 1'b1);
    check_output("clr cons_cnt", 16'(cons_cnt), 16'd0);
    check_output("clr ts_type", 16'(ts_type), 16'd0);
    check_output("clr enough", {14'd0, ts1_enough, ts2_enough}, 16'd0);
    check_output("clr lane_num hold", 16'(lane_num), 16'h01);
    check_output("clr rate_id hold", 16'(rate_id), 16'h02);
    check_output("clr bad_ts", 16'(bad_ts), 16'd0);
    apply_stimulus(ts1_b, 1'b1, 1'b0);
    check_output("post-clr cons_cnt", 16'(cons_cnt), 16'd1);

    $display("[TB] asynchronous reset mid-stream");
    apply_stimulus(ts1_b, 1'b1, 1'b0);
    #0.1;
    rst = 1'b0;
    #0.1;
    check_output("async rst cons_cnt", 16'(cons_cnt), 16'd0);
    check_output("async rst fields", {link_num, lane_num}, 16'd0);
    check_output("async rst flags", {10'd0, ts_type, ts1_enough, ts2_enough, bad_ts, rx_tmo}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(ts1_b, 1'b1, 1'b0);
    check_output("post-rst cons_cnt", 16'(cons_cnt), 16'd1);
    check_output("post-rst lane_num", 16'(lane_num), 16'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
